// File: rtl/bayer_gray_stream.sv
// Raw Bayer stream to grayscale: 2x2 sliding-window average with a one-row line buffer.
// One-cycle registered latency; no backpressure, input gaps simply stall all state.
module bayer_gray_stream #(
  parameter int ROW_SIZE   = 1280,
  parameter int NUM_ROWS   = 960,
  parameter int PIXEL_SIZE = 12,
  parameter int COORD_W    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_SIZE-1:0] raw_in,
  input  logic                  valid_in,
  output logic [PIXEL_SIZE-1:0] gray_out,
  output logic                  valid_out,
  output logic [COORD_W-1:0]    x_cont,
  output logic [COORD_W-1:0]    y_cont,
  output logic                  frame_done
);

  localparam int SUM_W = PIXEL_SIZE + 2;

  typedef enum logic {FIRST_ROW, STEADY} state_t;

  state_t                  state;
  logic [PIXEL_SIZE-1:0]   lbuf [ROW_SIZE];
  logic [COORD_W-1:0]      col;
  logic [COORD_W-1:0]      row;
  logic [PIXEL_SIZE-1:0]   left;
  logic [PIXEL_SIZE-1:0]   upper_left;
  logic [PIXEL_SIZE-1:0]   upper;
  logic                    last_col;
  logic                    last_row;
  logic [SUM_W-1:0]        sum2;
  logic [SUM_W-1:0]        sum4;
  logic [PIXEL_SIZE-1:0]   gray_next;

  // Upper neighbour is read from the column slot before this pixel overwrites it.
  assign upper    = lbuf[col];
  assign last_col = (col == COORD_W'(ROW_SIZE - 1));
  assign last_row = (row == COORD_W'(NUM_ROWS - 1));

  always_comb begin
    sum2      = SUM_W'(raw_in) + SUM_W'(upper);
    sum4      = sum2 + SUM_W'(left) + SUM_W'(upper_left);
    gray_next = raw_in;
    if (state == STEADY) begin
      if (col == '0) gray_next = PIXEL_SIZE'(sum2 >> 1);
      else           gray_next = PIXEL_SIZE'(sum4 >> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in && !rst) lbuf[col] <= raw_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FIRST_ROW;
      col        <= '0;
      row        <= '0;
      left       <= '0;
      upper_left <= '0;
      gray_out   <= '0;
      valid_out  <= 1'b0;
      x_cont     <= '0;
      y_cont     <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= valid_in;
      frame_done <= valid_in && last_col && last_row;
      if (valid_in) begin
        gray_out <= gray_next;
        x_cont   <= col;
        y_cont   <= row;
        if (last_col) begin
          col        <= '0;
          left       <= '0;
          upper_left <= '0;
          row        <= last_row ? '0 : row + 1'b1;
          if (state == FIRST_ROW)  state <= STEADY;
          else if (last_row)       state <= FIRST_ROW;
        end else begin
          col        <= col + 1'b1;
          left       <= raw_in;
          // Buffer contents are stale during the first row, so never latch them.
          upper_left <= (state == STEADY) ? upper : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_gray_stream.sv
// Directed bench for bayer_gray_stream on a reduced 8x4 frame.
module tb_bayer_gray_stream;

  localparam int R = 8;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] raw_in;
  logic        valid_in;
  logic [11:0] gray_out;
  logic        valid_out;
  logic [10:0] x_cont;
  logic [10:0] y_cont;
  logic        frame_done;

  logic [11:0] img [N][R];
  logic [11:0] got [N][R];
  int passed = 0;
  int total  = 0;
  int vcount;
  int fdcount;

  bayer_gray_stream #(.ROW_SIZE(R), .NUM_ROWS(N), .PIXEL_SIZE(12), .COORD_W(11)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .valid_in(valid_in),
    .gray_out(gray_out), .valid_out(valid_out), .x_cont(x_cont),
    .y_cont(y_cont), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] expv(input int x, input int y);
    int s;
    if (y == 0) return img[y][x];
    if (x == 0) begin
      s = int'(img[y][0]) + int'(img[y-1][0]);
      return 12'(s >> 1);
    end
    s = int'(img[y][x]) + int'(img[y][x-1]) + int'(img[y-1][x]) + int'(img[y-1][x-1]);
    return 12'(s >> 2);
  endfunction

  task automatic run_frame(input bit toggle);
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < R; x++) begin
        valid_in = 1'b1;
        raw_in   = img[y][x];
        @(posedge clk); #1;
        got[y][x] = gray_out;
        if (valid_out)  vcount++;
        if (frame_done) fdcount++;
        check("valid", 32'(valid_out), 32'd1);
        check("gray", 32'(gray_out), 32'(expv(x, y)));
        check("x_cont", 32'(x_cont), 32'(x));
        check("y_cont", 32'(y_cont), 32'(y));
        check("frame_done", 32'(frame_done), 32'((x == R-1) && (y == N-1)));
        if (toggle) begin
          valid_in = 1'b0;
          raw_in   = 12'hABC;
          @(posedge clk); #1;
          if (frame_done) fdcount++;
          check("gap_valid", 32'(valid_out), 32'd0);
          check("gap_gray_hold", 32'(gray_out), 32'(expv(x, y)));
          check("gap_x_hold", 32'(x_cont), 32'(x));
          check("gap_fd", 32'(frame_done), 32'd0);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; raw_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gray", 32'(gray_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_x", 32'(x_cont), 32'd0);
    check("rst_y", 32'(y_cont), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Ramp: row 0 passes through unchanged.
    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'(y * R + x);
    run_frame(1'b0);
    check("ramp_r0x5", 32'(got[0][5]), 32'd5);

    // Flat rows 0x100 / 0x300, then saturated rows.
    for (int y = 0; y < N; y++)
      for (int x = 0; x < R; x++)
        img[y][x] = (y == 0) ? 12'h100 : (y == 1) ? 12'h300 : 12'hFFF;
    run_frame(1'b0);
    check("flat_r1x0", 32'(got[1][0]), 32'h200);
    check("flat_r1x3", 32'(got[1][3]), 32'h200);
    check("sat_r3x5", 32'(got[3][5]), 32'hFFF);

    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'hFFF;
    run_frame(1'b0);
    check("allfff_r2x0", 32'(got[2][0]), 32'hFFF);
    check("allfff_r3x7", 32'(got[3][7]), 32'hFFF);

    // Truncation: 2+1+0+4 = 7 -> 1.
    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'h000;
    img[0][0] = 12'd4; img[0][1] = 12'd0; img[1][0] = 12'd1; img[1][1] = 12'd2;
    run_frame(1'b0);
    check("trunc_r1x0", 32'(got[1][0]), 32'd2);
    check("trunc_r1x1", 32'(got[1][1]), 32'd1);

    // Alternating valid, then back-to-back frame restarting at (0,0).
    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'($urandom);
    vcount = 0; fdcount = 0;
    run_frame(1'b1);
    check("toggle_vcount", 32'(vcount), 32'(R * N));
    check("toggle_fdcount", 32'(fdcount), 32'd1);
    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'($urandom);
    run_frame(1'b0);

    // Abort mid-frame at (5,2); reset wins over a simultaneous pixel.
    fdcount = 0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < R; x++) begin
        if (!(y == 2 && x >= 5)) begin
          valid_in = 1'b1; raw_in = 12'($urandom);
          @(posedge clk); #1;
          if (frame_done) fdcount++;
        end
      end
    end
    rst = 1'b1; valid_in = 1'b1; raw_in = 12'h7AB;
    @(posedge clk); #1;
    check("abort_gray", 32'(gray_out), 32'd0);
    check("abort_valid", 32'(valid_out), 32'd0);
    check("abort_x", 32'(x_cont), 32'd0);
    check("abort_y", 32'(y_cont), 32'd0);
    check("abort_fd", 32'(frame_done), 32'd0);
    rst = 1'b0; valid_in = 1'b0;
    check("abort_no_fd", 32'(fdcount), 32'd0);
    for (int y = 0; y < N; y++) for (int x = 0; x < R; x++) img[y][x] = 12'($urandom);
    run_frame(1'b0);
    check("after_abort_fd", 32'(fdcount), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
